// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver with a valid/ready output port.
// The frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional
// parity bit and STOP_BITS stop bits. Each received word is held with its
// parity and framing flags until the consumer accepts it.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: every bit decision becomes a
// 2-of-3 vote over the synchronized line around the sample point, which adds
// one clock of latency.
module uart_rx_core #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  parity_err_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY_TYPE == 1);
  localparam logic             PAR_EN    = (PARITY_TYPE != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    stop_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    perr_acc_q;
  logic                    ferr_acc_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    perr_q;
  logic                    ferr_q;
  logic                    overrun_q;

  logic sync1_q;
  logic sync2_q;
  logic rx_s;

  logic counting;
  logic tick;
  logic evt_d;
  logic bit_d;
  logic ferr_d;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s     = sync2_q;
  assign counting = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
  assign tick     = counting && (cnt_q == '0);

`ifdef UART_RX_MAJORITY_VOTE_EN
  function automatic logic maj3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

  logic [1:0] hist_q;
  logic       pend_q;

  // Line history plus a one-cycle delayed sample strobe, so the vote can see
  // the line one cycle before, at, and one cycle after the counter expiry.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hist_q <= 2'b11;
      pend_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], rx_s};
      pend_q <= tick;
    end
  end

  assign evt_d = pend_q;
  assign bit_d = maj3({hist_q, rx_s});
`else
  assign evt_d = tick;
  assign bit_d = rx_s;
`endif

  assign ferr_d = ferr_acc_q | ~bit_d;

  // Receive FSM with bit timing, deserializer and the output holding register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shreg_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // Handshake; a commit later in this block overrides it.
      if (valid_q && ready_i) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      // Free-running bit timer while inside a frame.
      if (counting) begin
        cnt_q <= (cnt_q == '0) ? CNT_FULL : cnt_q - 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_q      <= CNT_HALF;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (evt_d) begin
            if (!bit_d) begin
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (evt_d) begin
            shreg_q[idx_q] <= bit_d;
            if (idx_q == IDX_LAST) begin
              stop_q  <= 1'b0;
              state_q <= PAR_EN ? PARITY : STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (evt_d) begin
            perr_acc_q <= ((^shreg_q) ^ bit_d) != PAR_ODD;
            stop_q     <= 1'b0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (evt_d) begin
            ferr_acc_q <= ferr_d;
            if (stop_q == STOP_LAST) begin
              if (!valid_q || ready_i) begin
                data_q  <= shreg_q;
                perr_q  <= perr_acc_q;
                ferr_q  <= ferr_d;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= bit_d ? IDLE : WAIT_HIGH;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);

endmodule
